// File: rtl/sw_debounce.sv
// Switch input conditioner: two-flop synchroniser, per-bit debounce counter,
// registered rise/fall pulses and sticky write-one-to-clear change flags.
module sw_debounce #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_MAX = 500000,
  parameter int unsigned CNT_W   = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] clr_edge,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] edge_flag
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  state_e           st_c  [WIDTH];

  // Per-bit state is implied by whether the synchronised level disagrees with sw_db.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      st_c[i] = (sync2_q[i] == db_q[i]) ? ST_STABLE : ST_PENDING;
    end
  end

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    // Set beats clear so an event coinciding with a software clear is kept.
    flag_d  = (flag_q & ~clr_edge) | rise_q | fall_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (st_c[i] == ST_PENDING) begin
        if (cnt_q[i] == CntLast) begin
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      flag_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flag_q  <= flag_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_db     = db_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign edge_flag = flag_q;

endmodule
